// File: rtl/sw_sel_buf_pkg.sv
`default_nettype none
// ============================================================================
// sw_sel_buf_pkg : opcodes, byte-strobe constants and store-kind decode
// Rev 1.0
// ============================================================================
package sw_sel_buf_pkg;

  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  localparam logic [3:0] STRB_B0  = 4'b0001;
  localparam logic [3:0] STRB_B1  = 4'b0010;
  localparam logic [3:0] STRB_B2  = 4'b0100;
  localparam logic [3:0] STRB_B3  = 4'b1000;
  localparam logic [3:0] STRB_HLO = 4'b0011;
  localparam logic [3:0] STRB_HHI = 4'b1100;
  localparam logic [3:0] STRB_W   = 4'b1111;

  typedef enum logic [1:0] {
    SK_NONE = 2'd0,
    SK_B    = 2'd1,
    SK_H    = 2'd2,
    SK_W    = 2'd3
  } st_kind_e;

  function automatic st_kind_e store_kind(input logic [5:0] op);
    case (op)
      OP_SB:   return SK_B;
      OP_SH:   return SK_H;
      OP_SW:   return SK_W;
      default: return SK_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_sel_buf_store_fifo.sv
`default_nettype none
// ============================================================================
// sw_sel_buf_store_fifo : store-buffer FIFO exposing every entry's word address
// Rev 1.0
// ============================================================================
module sw_sel_buf_store_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [AW-3:0]              waddr_i,
  input  logic [3:0]                 wstrb_i,
  input  logic [31:0]                wdata_i,
  output logic [AW-3:0]              head_addr_o,
  output logic [3:0]                 head_strb_o,
  output logic [31:0]                head_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [DEPTH-1:0][AW-3:0]   ent_addr_o,
  output logic [DEPTH-1:0]           ent_valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-3:0] addr_q [DEPTH];
  logic [3:0]    strb_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Payload storage needs no reset: validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[wr_ptr_q] <= waddr_i;
      strb_q[wr_ptr_q] <= wstrb_i;
      data_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_strb_o = strb_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] w_off;
    assign w_off          = PW'(i) - rd_ptr_q;
    assign ent_valid_o[i] = ({1'b0, w_off} < count_q);
    assign ent_addr_o[i]  = addr_q[i];
  end

endmodule
`default_nettype wire

// File: rtl/sw_sel_buf.sv
`default_nettype none
// ============================================================================
// sw_sel_buf : store lane encoder, misalignment check, store buffer and
//              load-after-store hazard detect
// Rev 1.0
// ============================================================================
module sw_sel_buf
  import sw_sel_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          st_validM,
  input  logic [5:0]    opM,
  input  logic [AW-1:0] aluoutM,
  input  logic [31:0]   writedataM,
  input  logic          ld_validM,
  output logic          stall_stM,
  output logic          adesM,
  output logic          ld_hazardM,
  output logic          sb_empty,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_wstrb,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack
);

  st_kind_e kind;
  logic        mis;
  logic [3:0]  enc_strb;
  logic [31:0] enc_data;

  always_comb begin
    kind     = store_kind(opM);
    mis      = 1'b0;
    enc_strb = '0;
    enc_data = '0;
    case (kind)
      SK_B: begin
        enc_data = {4{writedataM[7:0]}};
        case (aluoutM[1:0])
          2'd0:    enc_strb = STRB_B0;
          2'd1:    enc_strb = STRB_B1;
          2'd2:    enc_strb = STRB_B2;
          default: enc_strb = STRB_B3;
        endcase
      end
      SK_H: begin
        enc_data = {2{writedataM[15:0]}};
        enc_strb = aluoutM[1] ? STRB_HHI : STRB_HLO;
        mis      = aluoutM[0];
      end
      SK_W: begin
        enc_data = writedataM;
        enc_strb = STRB_W;
        mis      = |aluoutM[1:0];
      end
      default: ;
    endcase
  end

  logic                     full, empty, push, pop;
  logic [AW-3:0]            head_addr;
  logic [3:0]               head_strb;
  logic [31:0]              head_data;
  logic [DEPTH-1:0][AW-3:0] ent_addr;
  logic [DEPTH-1:0]         ent_valid;

  // A full buffer refuses the push even if the head retires this cycle.
  assign push = st_validM & (kind != SK_NONE) & ~mis & ~full;
  assign pop  = mem_req & mem_ack;

  sw_sel_buf_store_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .waddr_i     (aluoutM[AW-1:2]),
    .wstrb_i     (enc_strb),
    .wdata_i     (enc_data),
    .head_addr_o (head_addr),
    .head_strb_o (head_strb),
    .head_data_o (head_data),
    .full_o      (full),
    .empty_o     (empty),
    .ent_addr_o  (ent_addr),
    .ent_valid_o (ent_valid)
  );

  assign adesM     = st_validM & mis;
  assign stall_stM = st_validM & full;
  assign sb_empty  = empty;
  assign mem_req   = ~empty;
  assign mem_addr  = mem_req ? {head_addr, 2'b00} : '0;
  assign mem_wstrb = mem_req ? head_strb : '0;
  assign mem_wdata = mem_req ? head_data : '0;

  logic hit;
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == aluoutM[AW-1:2])) hit = 1'b1;
    end
  end
  assign ld_hazardM = ld_validM & hit;

endmodule
`default_nettype wire

// File: tb/tb_sw_sel_buf.sv
`default_nettype none
// ============================================================================
// tb_sw_sel_buf : directed + random checks against a queue-based store model
// Rev 1.0
// ============================================================================
module tb_sw_sel_buf;
  import sw_sel_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          st_validM, ld_validM, mem_ack;
  logic [5:0]    opM;
  logic [AW-1:0] aluoutM;
  logic [31:0]   writedataM;
  logic          stall_stM, adesM, ld_hazardM, sb_empty, mem_req;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;

  sw_sel_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_validM  (st_validM),
    .opM        (opM),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .ld_validM  (ld_validM),
    .stall_stM  (stall_stM),
    .adesM      (adesM),
    .ld_hazardM (ld_hazardM),
    .sb_empty   (sb_empty),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the byte/half/word rules using plain arithmetic.
  task automatic encode(output bit is_st, output bit mis, output logic [3:0] s,
                        output logic [31:0] d);
    int unsigned a;
    a     = aluoutM % 4;
    is_st = 1'b1;
    mis   = 1'b0;
    s     = 4'd0;
    d     = 32'd0;
    if (opM == OP_SB) begin
      s = 4'(1 << a);
      d = {24'd0, writedataM[7:0]} * 32'h0101_0101;
    end else if (opM == OP_SH) begin
      mis = (a % 2) != 0;
      s   = 4'(3 << (a - a % 2));
      d   = {16'd0, writedataM[15:0]} * 32'h0001_0001;
    end else if (opM == OP_SW) begin
      mis = a != 0;
      s   = 4'hF;
      d   = writedataM;
    end else begin
      is_st = 1'b0;
    end
  endtask

  // Check every output at the falling edge, then retire/accept at the rising edge.
  task automatic step();
    bit          is_st, mis, hz, do_push;
    logic [3:0]  s;
    logic [31:0] d;
    @(negedge clk);
    encode(is_st, mis, s, d);
    hz = 1'b0;
    foreach (q[i]) if ((q[i].addr >> 2) == (aluoutM >> 2)) hz = 1'b1;
    chk("adesM",     32'(adesM),      32'(st_validM & is_st & mis));
    chk("stall",     32'(stall_stM),  32'(st_validM && q.size() == DEPTH));
    chk("hazard",    32'(ld_hazardM), 32'(ld_validM & hz));
    chk("sb_empty",  32'(sb_empty),   32'(q.size() == 0));
    chk("mem_req",   32'(mem_req),    32'(q.size() != 0));
    chk("mem_addr",  mem_addr,        q.size() != 0 ? q[0].addr : 32'd0);
    chk("mem_wstrb", 32'(mem_wstrb),  q.size() != 0 ? 32'(q[0].strb) : 32'd0);
    chk("mem_wdata", mem_wdata,       q.size() != 0 ? q[0].data : 32'd0);
    do_push = st_validM & is_st & ~mis & (q.size() < DEPTH);
    @(posedge clk);
    if (q.size() != 0 && mem_ack) void'(q.pop_front());
    if (do_push) q.push_back('{addr: {aluoutM[31:2], 2'b00}, strb: s, data: d});
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic ld, input logic ack);
    st_validM  = v;
    opM        = op;
    aluoutM    = a;
    writedataM = wd;
    ld_validM  = ld;
    mem_ack    = ack;
  endtask

  initial begin
    logic [5:0] ops [4];
    ops[0] = OP_SB; ops[1] = OP_SH; ops[2] = OP_SW; ops[3] = 6'h23;

    rst = 1'b1;
    drive(0, 6'h0, 32'h0, 32'h0, 0, 0);
    #1;
    chk("rst_mem_req",  32'(mem_req),   32'd0);
    chk("rst_sb_empty", 32'(sb_empty),  32'd1);
    chk("rst_mem_addr", mem_addr,       32'd0);
    chk("rst_stall",    32'(stall_stM), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SB with ack held high: presented next cycle, retired in one.
    drive(1, OP_SB, 32'h1001, 32'h0000_00AB, 0, 1); step();
    drive(0, OP_SB, 32'h1001, 32'h0, 0, 1);         step();
    chk("sb_example_empty", 32'(sb_empty), 32'd1);

    // SH aligned then misaligned.
    drive(1, OP_SH, 32'h2002, 32'hFFFF_1234, 0, 0); step();
    drive(0, OP_SH, 32'h2002, 32'h0, 0, 1);         step();
    drive(1, OP_SH, 32'h2003, 32'hFFFF_1234, 0, 1); step();
    drive(0, OP_SH, 32'h0, 32'h0, 0, 1);            step();

    // SW aligned then misaligned.
    drive(1, OP_SW, 32'h3004, 32'hDEAD_BEEF, 0, 0); step();
    drive(1, OP_SW, 32'h3006, 32'hCAFE_F00D, 0, 0); step();
    drive(0, OP_SW, 32'h0, 32'h0, 0, 1);            step();

    // Fill with ack low, stall the fifth, one ack frees a slot.
    for (int i = 0; i < 4; i++) begin
      drive(1, OP_SW, 32'h40 + 32'(4 * i), 32'h100 + 32'(i), 0, 0); step();
    end
    drive(1, OP_SW, 32'h50, 32'h5555_5555, 0, 0); step();
    chk("full_stall", 32'(stall_stM), 32'd1);
    drive(1, OP_SW, 32'h50, 32'h5555_5555, 0, 1); step();
    drive(1, OP_SW, 32'h50, 32'h5555_5555, 0, 0); step();
    for (int i = 0; i < 5; i++) begin
      drive(0, OP_SW, 32'h0, 32'h0, 0, 1); step();
    end

    // Load hazard against a pending SB.
    drive(1, OP_SB, 32'h5003, 32'h77, 0, 0);  step();
    drive(0, OP_SB, 32'h5000, 32'h0, 1, 0);   step();
    chk("hazard_hit", 32'(ld_hazardM), 32'd1);
    drive(0, OP_SB, 32'h5004, 32'h0, 1, 0);   step();
    drive(0, OP_SB, 32'h5000, 32'h0, 1, 1);   step();
    drive(0, OP_SB, 32'h5000, 32'h0, 1, 0);   step();
    chk("hazard_clear", 32'(ld_hazardM), 32'd0);

    // Mid-cycle reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_SW, 32'h600 + 32'(4 * i), 32'h600 + 32'(i), 0, 0); step();
    end
    drive(0, OP_SW, 32'h0, 32'h0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_mem_req",  32'(mem_req),  32'd0);
    chk("midrst_sb_empty", 32'(sb_empty), 32'd1);
    q.delete();
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, OP_SW, 32'h0, 32'h0, 0, 1); step();
    end

    // Random traffic over a small address window to provoke hazards and fills.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), ops[$urandom_range(0, 3)],
            32'h100 + 32'($urandom_range(0, 23)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 40));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
